// File: rtl/disp_scan_seq_pkg.sv
// Shared definitions for the display-source sequencer: mode encodings,
// default datapath widths and the blank (all segments off) display word.
package disp_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SCAN = 2'b01,
    MODE_STEP = 2'b10,
    MODE_PLAY = 2'b11
  } mode_e;

  localparam int DATA_W = 32;
  localparam int DISP_W = 64;

  // seg7x16 segments are active-low, so all-ones blanks every digit
  localparam logic [DISP_W-1:0] DISP_BLANK = '1;

endpackage

// File: rtl/disp_scan_seq_tick_gen.sv
// Programmable prescaler: emits a one-cycle tick every (max_i + 1) cycles.
// Lowering max_i below the running count lets the counter wrap through
// 2^DIV_W before the next tick; that is intentional and left unguarded.
module tick_gen #(
  parameter int DIV_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] max_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Terminal-count compare and counter advance
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (cnt_q == max_i) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and registered tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/disp_scan_seq.sv
// Display-source sequencer for the seg7x16 driver. Picks one of NCH probe
// channels (HOLD/SCAN/STEP) or replays words from an external synchronous
// pattern ROM (PLAY), producing one registered DISP_W word per update.
module disp_scan_seq #(
  parameter int  NCH    = 4,
  parameter int  DATA_W = disp_seq_pkg::DATA_W,
  parameter int  DISP_W = disp_seq_pkg::DISP_W,
  parameter int  PAT_AW = 6,
  parameter int  DIV_W  = 28,
  localparam int SEL_W  = $clog2(NCH),
  localparam int IDX_W  = (SEL_W > PAT_AW) ? SEL_W : PAT_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode_i,
  input  logic [DIV_W-1:0]      div_max_i,
  input  logic                  pause_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  step_i,
  input  logic [PAT_AW-1:0]     pat_len_i,
  input  logic [NCH*DATA_W-1:0] probe_i,
  output logic [PAT_AW-1:0]     pat_addr_o,
  input  logic [DISP_W-1:0]     pat_data_i,
  output logic [DISP_W-1:0]     disp_data_o,
  output logic                  disp_gfx_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  tick_o,
  output logic                  upd_o
);
  import disp_seq_pkg::*;

  mode_e             mode_q;
  logic              step_q;
  logic              tick;
  logic              mode_chg;
  logic              step_rise;
  logic              adv;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAT_AW-1:0] pat_addr_q;
  logic              adv_q, adv2_q;
  logic              upd_q, upd_d;
  logic              rom_vld_q;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              gfx_q, gfx_d;
  logic [DATA_W-1:0] ch;

  // A mode change restarts the prescaler so the new mode begins a full period
  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst | mode_chg),
    .max_i  (div_max_i),
    .tick_o (tick)
  );

  // Index sequencing: mode-change clear has priority over any advance
  always_comb begin
    mode_chg  = (mode_i != mode_q);
    step_rise = step_i & ~step_q;
    adv       = 1'b0;
    idx_d     = idx_q;
    if (mode_chg) begin
      idx_d = '0;
    end else begin
      unique case (mode_e'(mode_i))
        MODE_HOLD: idx_d = IDX_W'(sel_i);
        MODE_SCAN: adv   = tick & ~pause_i;
        MODE_STEP: adv   = step_rise & ~pause_i;
        MODE_PLAY: adv   = tick & ~pause_i;
        default:   adv   = 1'b0;
      endcase
      if (adv) begin
        if (mode_e'(mode_i) == MODE_PLAY)
          idx_d = (idx_q >= IDX_W'(pat_len_i)) ? '0 : idx_q + IDX_W'(1);
        else
          idx_d = (idx_q >= IDX_W'(NCH - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Probe channel addressed by the current index (zero when out of range)
  always_comb begin
    ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) ch = probe_i[k*DATA_W +: DATA_W];
    end
  end

  // Display word: probes refresh every cycle; PLAY waits for a valid ROM read
  always_comb begin
    disp_d = disp_q;
    gfx_d  = gfx_q;
    upd_d  = (mode_q == MODE_PLAY) ? adv2_q : adv_q;
    if (mode_q == MODE_PLAY) begin
      if (rom_vld_q) begin
        disp_d = pat_data_i;
        gfx_d  = 1'b1;
      end
    end else begin
      gfx_d  = 1'b0;
      disp_d = (idx_q >= IDX_W'(NCH)) ? DISP_W'(DISP_BLANK) : DISP_W'(ch);
    end
  end

  // State, ROM address, update delay line and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_HOLD;
      step_q     <= 1'b0;
      idx_q      <= '0;
      pat_addr_q <= '0;
      adv_q      <= 1'b0;
      adv2_q     <= 1'b0;
      upd_q      <= 1'b0;
      rom_vld_q  <= 1'b0;
      disp_q     <= '0;
      gfx_q      <= 1'b0;
    end else begin
      mode_q     <= mode_e'(mode_i);
      step_q     <= step_i;
      idx_q      <= idx_d;
      pat_addr_q <= idx_d[PAT_AW-1:0];
      adv_q      <= adv;
      adv2_q     <= adv_q;
      upd_q      <= upd_d;
      // ROM data is trusted only if its address was issued while in PLAY
      rom_vld_q  <= (mode_q == MODE_PLAY);
      disp_q     <= disp_d;
      gfx_q      <= gfx_d;
    end
  end

  assign pat_addr_o  = pat_addr_q;
  assign disp_data_o = disp_q;
  assign disp_gfx_o  = gfx_q;
  assign idx_o       = idx_q;
  assign tick_o      = tick;
  assign upd_o       = upd_q;

endmodule

// File: tb/tb_disp_scan_seq.sv
// Bench for disp_scan_seq. A five-channel instance is used so that select
// values beyond the last channel exist and the blank word can be observed.
module tb_disp_scan_seq;

  localparam int NCH    = 5;
  localparam int DATA_W = 32;
  localparam int DISP_W = 64;
  localparam int PAT_AW = 6;
  localparam int DIV_W  = 28;
  localparam int SEL_W  = 3;
  localparam int IDX_W  = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            mode;
  logic [DIV_W-1:0]      div;
  logic                  pause;
  logic [SEL_W-1:0]      sel;
  logic                  step;
  logic [PAT_AW-1:0]     pat_len;
  logic [NCH*DATA_W-1:0] probe;
  logic [PAT_AW-1:0]     pat_addr;
  logic [DISP_W-1:0]     pat_data;
  logic [DISP_W-1:0]     disp;
  logic                  gfx;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  upd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  disp_scan_seq #(
    .NCH(NCH), .DATA_W(DATA_W), .DISP_W(DISP_W), .PAT_AW(PAT_AW), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .div_max_i(div), .pause_i(pause),
    .sel_i(sel), .step_i(step), .pat_len_i(pat_len), .probe_i(probe),
    .pat_addr_o(pat_addr), .pat_data_i(pat_data), .disp_data_o(disp),
    .disp_gfx_o(gfx), .idx_o(idx), .tick_o(tick), .upd_o(upd)
  );

  // Synchronous pattern ROM: word = address * 0x0101, one cycle latency
  always_ff @(posedge clk) pat_data <= DISP_W'(pat_addr) * 64'h0101;

  // Reference model state (values the outputs must show after the last edge)
  bit          m_known = 0;
  int          m_cnt, m_idx, m_pmode;
  bit          m_tick, m_pstep, m_gfx, m_upd;
  logic [63:0] m_disp;
  int          h_idx[3];   // [0] = idx after last edge, [1] one edge earlier ...
  int          h_mode[3];  // mode sampled at that edge, -1 = reset edge
  bit          h_adv[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] probe_word(input int i);
    return probe[i*DATA_W +: DATA_W];
  endfunction

  // Apply the behavioural rules for the edge about to happen
  task automatic model_edge();
    int  nidx, mq;
    bit  chg, a, rise;
    if (rst) begin
      m_known = 1; m_cnt = 0; m_tick = 0; m_idx = 0; m_pmode = 0; m_pstep = 0;
      m_disp = '0; m_gfx = 0; m_upd = 0;
      for (int k = 0; k < 3; k++) begin h_idx[k] = 0; h_mode[k] = -1; h_adv[k] = 0; end
      return;
    end
    if (!m_known) return;
    chg  = (int'(mode) != m_pmode);
    rise = step && !m_pstep;
    a    = 0;
    nidx = m_idx;
    if (chg) nidx = 0;
    else begin
      case (int'(mode))
        0: nidx = int'(sel);
        1: if (m_tick && !pause) begin a = 1; nidx = (m_idx + 1) % NCH; end
        2: if (rise && !pause)   begin a = 1; nidx = (m_idx + 1) % NCH; end
        default: if (m_tick && !pause) begin a = 1; nidx = (m_idx >= int'(pat_len)) ? 0 : m_idx + 1; end
      endcase
    end
    // prescaler period is div+1 cycles, restarted by a mode change
    if (chg) begin m_cnt = 0; m_tick = 0; end
    else if (m_cnt == int'(div)) begin m_cnt = 0; m_tick = 1; end
    else begin m_cnt = (m_cnt + 1) % (1 << DIV_W); m_tick = 0; end
    // output word reflects idx one edge back (probes) or two edges back (ROM)
    mq = (h_mode[0] < 0) ? 0 : h_mode[0];
    if (mq != 3) begin
      m_gfx  = 0;
      m_disp = (h_idx[0] >= NCH) ? {DISP_W{1'b1}} : DISP_W'(probe_word(h_idx[0]));
      m_upd  = h_adv[0];
    end else begin
      if (h_mode[1] == 3) begin
        m_disp = DISP_W'(h_idx[1]) * 64'h0101;
        m_gfx  = 1;
      end
      m_upd = h_adv[1];
    end
    for (int k = 2; k > 0; k--) begin
      h_idx[k] = h_idx[k-1]; h_mode[k] = h_mode[k-1]; h_adv[k] = h_adv[k-1];
    end
    h_idx[0] = nidx; h_mode[0] = int'(mode); h_adv[0] = a;
    m_idx = nidx; m_pmode = int'(mode); m_pstep = step;
  endtask

  task automatic check_outputs();
    if (!m_known) return;
    chk("idx", 64'(idx), 64'(m_idx));
    chk("pat_addr", 64'(pat_addr), 64'(m_idx % 64));
    chk("tick", 64'(tick), 64'(m_tick));
    chk("upd", 64'(upd), 64'(m_upd));
    chk("disp", disp, m_disp);
    chk("gfx", 64'(gfx), 64'(m_gfx));
  endtask

  task automatic step_cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_probe();
    for (int k = 0; k < NCH; k++) probe[k*DATA_W +: DATA_W] = $urandom;
  endtask

  initial begin
    int nt, idx_before, wrap_seen;
    logic [63:0] last_w;
    rst = 1; mode = 2'b00; div = 3; pause = 0; sel = 2; step = 0; pat_len = 18;
    rand_probe();
    probe[2*DATA_W +: DATA_W] = 32'h0000_ABCD;
    step_cycle();
    step_cycle();
    chk("rst_disp", disp, 64'h0);
    chk("rst_idx", 64'(idx), 64'h0);
    rst = 0;

    // HOLD: in-range and out-of-range selects
    for (int i = 0; i < 3; i++) step_cycle();
    chk("hold_sel2", disp, 64'h0000_0000_0000_ABCD);
    chk("hold_gfx", 64'(gfx), 64'h0);
    sel = 5;
    for (int i = 0; i < 3; i++) step_cycle();
    chk("hold_blank", disp, 64'hFFFF_FFFF_FFFF_FFFF);

    // SCAN with div 3, then pause for 8 cycles
    mode = 2'b01;
    for (int i = 0; i < 14; i++) begin rand_probe(); step_cycle(); end
    idx_before = int'(idx);
    pause = 1; nt = 0;
    for (int i = 0; i < 8; i++) begin step_cycle(); if (tick) nt++; end
    chk("pause_idx", 64'(idx), 64'(idx_before));
    chk("pause_ticks", 64'(nt), 64'd2);
    pause = 0;

    // STEP: long level, then two single-cycle pulses
    mode = 2'b10; step = 0;
    step_cycle(); step_cycle();
    step = 1; for (int i = 0; i < 10; i++) step_cycle();
    step = 0; step_cycle(); step_cycle();
    step = 1; step_cycle();
    step = 0; step_cycle(); step_cycle();
    step = 1; step_cycle();
    step = 0; step_cycle(); step_cycle();
    chk("step_idx", 64'(idx), 64'd3);

    // SCAN until a tick is visible, then switch to PLAY on that tick
    mode = 2'b01; nt = 0;
    for (int i = 0; i < 40 && nt < 2; i++) begin step_cycle(); if (tick) nt++; end
    chk("scan_tick_wait", 64'(nt), 64'd2);
    mode = 2'b11; div = 0; pat_len = 18;
    step_cycle();
    chk("chg_idx", 64'(idx), 64'h0);
    chk("chg_upd", 64'(upd), 64'h0);
    chk("chg_tick", 64'(tick), 64'h0);

    // PLAY through address 18 and back to 0
    wrap_seen = 0; last_w = '1;
    for (int i = 0; i < 60; i++) begin
      step_cycle();
      if (upd) begin
        chk("play_gfx", 64'(gfx), 64'h1);
        if (last_w == 64'h1212) begin
          chk("play_wrap_word", disp, 64'h0);
          wrap_seen++;
        end
        last_w = disp;
      end
    end
    chk("play_wrap_seen", 64'(wrap_seen > 0), 64'h1);

    // Reset in the middle of playback
    rst = 1;
    step_cycle();
    chk("mid_rst_disp", disp, 64'h0);
    chk("mid_rst_gfx", 64'(gfx), 64'h0);
    chk("mid_rst_addr", 64'(pat_addr), 64'h0);
    chk("mid_rst_upd", 64'(upd), 64'h0);
    chk("mid_rst_tick", 64'(tick), 64'h0);
    rst = 0;

    // Randomized segments; the prescaler limit only moves with a mode change
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      len = $urandom_range(4, 30);
      if ($urandom_range(0, 2) != 0) begin
        mode = 2'((int'(mode) + $urandom_range(1, 3)) % 4);
        div  = DIV_W'($urandom_range(0, 4));
      end
      pat_len = PAT_AW'($urandom_range(0, 20));
      for (int i = 0; i < len; i++) begin
        pause = ($urandom_range(0, 5) == 0);
        step  = 1'($urandom_range(0, 1));
        sel   = SEL_W'($urandom);
        rst   = ($urandom_range(0, 150) == 0);
        rand_probe();
        step_cycle();
        rst = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
